wb_arbiter: RTL and testbench

//  Writeback arbiter; drives the single register-file write port (rf_we/rf_rd/rf_wd).

---
 rtl/zaks_pkg.sv | 15 +
 rtl/wb_fifo.sv | 66 ++++++
 rtl/wb_arbiter.sv | 110 +++++++++++
 tb/tb_wb_arbiter.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/zaks_pkg.sv
// Shared writeback types and sizing for the register-file write path.
package zaks_pkg;
  localparam int XLEN       = 32;
  localparam int AW         = 4;
  localparam int NREGS      = 2 ** AW;
  localparam int LQ_DEPTH   = 4;
  localparam int STARVE_MAX = 4;

  typedef logic [AW-1:0] reg_idx_t;

  typedef struct packed {
    reg_idx_t          rd;
    logic [XLEN-1:0]   data;
  } wb_entry_t;
endpackage

// File: rtl/wb_fifo.sv
// Load-result FIFO; exposes head, occupancy and per-slot rd so pending writes can be tracked.
module wb_fifo
  import zaks_pkg::*;
#(
  parameter int DEPTH = LQ_DEPTH,
  localparam int PW   = $clog2(DEPTH),
  localparam int CW   = PW + 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     enq,
  input  wb_entry_t                enq_entry,
  input  logic                     deq,
  output wb_entry_t                head,
  output logic [CW-1:0]            count,
  output logic [DEPTH-1:0]         entry_valid,
  output logic [DEPTH-1:0][AW-1:0] entry_rd
);
  wb_entry_t      mem_reg [DEPTH];
  logic [PW-1:0]  wr_ptr_reg, rd_ptr_reg;
  logic [CW-1:0]  count_reg, count_next;
  logic           do_enq, do_deq;

  // Full/empty guards live here so the FIFO stays consistent whatever the caller asks.
  assign do_enq = enq && (count_reg != CW'(DEPTH));
  assign do_deq = deq && (count_reg != '0);

  always_comb begin
    count_next = count_reg;
    case ({do_enq, do_deq})
      2'b10:   count_next = count_reg + 1'b1;
      2'b01:   count_next = count_reg - 1'b1;
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_enq) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_deq) rd_ptr_reg <= rd_ptr_reg + 1'b1;
      count_reg <= count_next;
    end
  end

  always_ff @(posedge clk) begin
    if (do_enq) mem_reg[wr_ptr_reg] <= enq_entry;
  end

  assign head  = mem_reg[rd_ptr_reg];
  assign count = count_reg;

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_slot
      logic [PW-1:0] offset;
      // Slot is live when its distance from the read pointer is below the occupancy.
      assign offset          = PW'(gi) - rd_ptr_reg;
      assign entry_valid[gi] = ({1'b0, offset} < count_reg);
      assign entry_rd[gi]    = mem_reg[gi].rd;
    end
  endgenerate
endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: one registered register-file write per cycle from ALU or queued loads,
// with anti-starvation forcing and a pending-destination mask for issue logic.
module wb_arbiter
  import zaks_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             alu_valid,
  output logic             alu_ready,
  input  logic [AW-1:0]    alu_rd,
  input  logic [XLEN-1:0]  alu_data,
  input  logic             lsu_valid,
  output logic             lsu_ready,
  input  logic [AW-1:0]    lsu_rd,
  input  logic [XLEN-1:0]  lsu_data,
  output logic             rf_we,
  output logic [AW-1:0]    rf_rd,
  output logic [XLEN-1:0]  rf_wd,
  output logic [NREGS-1:0] pend_mask
);
  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam int CW = $clog2(LQ_DEPTH) + 1;

  wb_entry_t                  fifo_head, win_entry;
  logic [CW-1:0]              fifo_count;
  logic [LQ_DEPTH-1:0]        entry_valid;
  logic [LQ_DEPTH-1:0][AW-1:0] entry_rd;
  logic [SW-1:0]              starve_reg, starve_next;
  logic                       rf_we_reg;
  logic [AW-1:0]              rf_rd_reg;
  logic [XLEN-1:0]            rf_wd_reg;
  logic                       lq_nonempty, force_fifo, alu_win, win_valid, deq;

  wb_fifo #(.DEPTH(LQ_DEPTH)) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .enq         (lsu_valid && lsu_ready),
    .enq_entry   ('{rd: lsu_rd, data: lsu_data}),
    .deq         (deq),
    .head        (fifo_head),
    .count       (fifo_count),
    .entry_valid (entry_valid),
    .entry_rd    (entry_rd)
  );

  assign lq_nonempty = (fifo_count != '0);
  assign force_fifo  = (starve_reg == SW'(STARVE_MAX)) && lq_nonempty;
  // A pending load to the same rd blocks the ALU so it can never overtake it.
  assign alu_ready   = !force_fifo && !pend_mask[alu_rd];
  assign lsu_ready   = (fifo_count != CW'(LQ_DEPTH));
  assign alu_win     = alu_valid && alu_ready;

  always_comb begin
    deq         = 1'b0;
    win_valid   = 1'b0;
    win_entry   = '0;
    starve_next = starve_reg;
    if (force_fifo) begin
      deq         = 1'b1;
      win_valid   = 1'b1;
      win_entry   = fifo_head;
      starve_next = '0;
    end else if (alu_win) begin
      win_valid   = 1'b1;
      win_entry   = '{rd: alu_rd, data: alu_data};
      starve_next = lq_nonempty ? starve_reg + 1'b1 : '0;
    end else if (lq_nonempty) begin
      deq         = 1'b1;
      win_valid   = 1'b1;
      win_entry   = fifo_head;
      starve_next = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      starve_reg <= '0;
      rf_we_reg  <= 1'b0;
      rf_rd_reg  <= '0;
      rf_wd_reg  <= '0;
    end else begin
      starve_reg <= starve_next;
      // r0 writes complete their handshake but are suppressed at the port.
      rf_we_reg  <= win_valid && (win_entry.rd != '0);
      if (win_valid) begin
        rf_rd_reg <= win_entry.rd;
        rf_wd_reg <= win_entry.data;
      end
    end
  end

  assign rf_we = rf_we_reg;
  assign rf_rd = rf_rd_reg;
  assign rf_wd = rf_wd_reg;

  genvar gi, gj;
  generate
    for (gi = 0; gi < NREGS; gi++) begin : g_pend
      if (gi == 0) begin : g_r0
        assign pend_mask[gi] = 1'b0;
      end else begin : g_rn
        logic [LQ_DEPTH-1:0] q_hit;
        for (gj = 0; gj < LQ_DEPTH; gj++) begin : g_q
          assign q_hit[gj] = entry_valid[gj] && (entry_rd[gj] == AW'(gi));
        end
        assign pend_mask[gi] = (|q_hit) || (rf_we_reg && (rf_rd_reg == AW'(gi)));
      end
    end
  endgenerate
endmodule

// File: tb/tb_wb_arbiter.sv
// Scoreboard bench for wb_arbiter: a queue-based reference predicts readys, mask and writes.
module tb_wb_arbiter;
  import zaks_pkg::*;

  logic             clk = 1'b0;
  logic             rst;
  logic             alu_valid, alu_ready, lsu_valid, lsu_ready, rf_we;
  logic [AW-1:0]    alu_rd, lsu_rd, rf_rd;
  logic [XLEN-1:0]  alu_data, lsu_data, rf_wd;
  logic [NREGS-1:0] pend_mask;

  always #5 clk = ~clk;

  wb_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .alu_valid (alu_valid),
    .alu_ready (alu_ready),
    .alu_rd    (alu_rd),
    .alu_data  (alu_data),
    .lsu_valid (lsu_valid),
    .lsu_ready (lsu_ready),
    .lsu_rd    (lsu_rd),
    .lsu_data  (lsu_data),
    .rf_we     (rf_we),
    .rf_rd     (rf_rd),
    .rf_wd     (rf_wd),
    .pend_mask (pend_mask)
  );

  typedef struct { logic [3:0] rd; logic [31:0] data; } op_t;
  typedef struct { logic we; logic [3:0] rd; logic [31:0] data; bit chk_all; } exp_t;

  op_t   alu_q[$], lsu_q[$], m_lq[$];
  exp_t  sb[$];
  int    m_starve;
  logic  m_we;
  logic [3:0]  m_rd;
  logic [31:0] shadow [16];
  int    checks = 0, failures = 0;
  int    r0_writes = 0, forced_cnt = 0, full_cycles = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] model_pend();
    logic [15:0] m = '0;
    foreach (m_lq[i]) m[m_lq[i].rd] = 1'b1;
    if (m_we) m[m_rd] = 1'b1;
    m[0] = 1'b0;
    return m;
  endfunction

  // Called just after a falling edge; returns just after the next falling edge.
  task automatic step();
    op_t a, l, win;
    bit av, lv, force_f, exp_ar, exp_lr, alu_acc, lsu_acc, have_win;
    int cnt;
    exp_t e, nxt;
    logic [15:0] pm;
    av = (alu_q.size() != 0);
    lv = (lsu_q.size() != 0);
    if (av) a = alu_q[0]; else a = '{rd: 4'($urandom), data: $urandom};
    if (lv) l = lsu_q[0]; else l = '{rd: 4'($urandom), data: $urandom};
    alu_valid = av; alu_rd = a.rd; alu_data = a.data;
    lsu_valid = lv; lsu_rd = l.rd; lsu_data = l.data;
    #1;
    cnt     = m_lq.size();
    pm      = model_pend();
    force_f = (m_starve == STARVE_MAX) && (cnt != 0);
    exp_ar  = !force_f && !pm[a.rd];
    exp_lr  = (cnt != LQ_DEPTH);
    check("alu_ready", alu_ready, exp_ar);
    check("lsu_ready", lsu_ready, exp_lr);
    check("pend_mask", pend_mask, pm);
    if (lsu_ready === 1'b0) full_cycles++;
    if (sb.size() != 0) begin
      e = sb.pop_front();
      check("rf_we", rf_we, e.we);
      if (e.we || e.chk_all) begin
        check("rf_rd", rf_rd, e.rd);
        check("rf_wd", rf_wd, e.data);
      end
    end
    if (rf_we === 1'b1) begin
      shadow[rf_rd] = rf_wd;
      if (rf_rd == 0) r0_writes++;
      $display("write r%0d = 0x%08h", rf_rd, rf_wd);
    end
    alu_acc  = av && exp_ar;
    have_win = 1'b0;
    win      = '{rd: 4'd0, data: 32'd0};
    if (force_f) begin
      win = m_lq.pop_front(); m_starve = 0; have_win = 1'b1; forced_cnt++;
    end else if (alu_acc) begin
      win = a; m_starve = (cnt != 0) ? m_starve + 1 : 0; have_win = 1'b1;
    end else if (cnt != 0) begin
      win = m_lq.pop_front(); m_starve = 0; have_win = 1'b1;
    end
    lsu_acc = lv && exp_lr;
    if (lsu_acc) m_lq.push_back(l);
    nxt.we = have_win && (win.rd != 0); nxt.rd = win.rd; nxt.data = win.data; nxt.chk_all = 1'b0;
    m_we = nxt.we;
    m_rd = nxt.rd;
    sb.push_back(nxt);
    if (alu_acc) void'(alu_q.pop_front());
    if (lsu_acc) void'(lsu_q.pop_front());
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    alu_valid = 1'b1; alu_rd = 4'd2; alu_data = 32'hDEAD;
    lsu_valid = 1'b1; lsu_rd = 4'd3; lsu_data = 32'hBEEF;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    alu_valid = 1'b0; lsu_valid = 1'b0;
    alu_q.delete(); lsu_q.delete(); m_lq.delete(); sb.delete();
    m_starve = 0; m_we = 1'b0; m_rd = '0;
    sb.push_back('{we: 1'b0, rd: 4'd0, data: 32'd0, chk_all: 1'b1});
  endtask

  task automatic drain(input int budget);
    int n = 0;
    bit busy;
    busy = 1'b1;
    while (busy && n < budget) begin
      step();
      n++;
      busy = (alu_q.size() != 0) || (lsu_q.size() != 0) || (m_lq.size() != 0) || m_we;
    end
    check("drain_timeout", busy, 1'b0);
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    foreach (shadow[i]) shadow[i] = '0;
    rst = 1'b1; alu_valid = 1'b0; lsu_valid = 1'b0;
    alu_rd = '0; lsu_rd = '0; alu_data = '0; lsu_data = '0;
    @(negedge clk);
    do_reset();
    step();

    // Back-to-back ALU results
    alu_q.push_back('{rd: 4'd3, data: 32'h11});
    alu_q.push_back('{rd: 4'd5, data: 32'h22});
    drain(20);
    check("alu_r3", shadow[3], 32'h11);
    check("alu_r5", shadow[5], 32'h22);

    // Loads queue up behind a continuous ALU stream until forced through
    forced_cnt = 0;
    for (int i = 1; i <= 4; i++) lsu_q.push_back('{rd: 4'(i), data: 32'h100 + i});
    for (int i = 0; i < 12; i++) alu_q.push_back('{rd: 4'(7 + (i % 2)), data: 32'h700 + i});
    drain(100);
    check("starve_forced", forced_cnt != 0, 1'b1);
    check("starve_r1", shadow[1], 32'h101);
    check("starve_r4", shadow[4], 32'h104);

    // Fifth load sees a full FIFO
    full_cycles = 0;
    for (int i = 0; i < 5; i++) lsu_q.push_back('{rd: 4'(9 + i), data: 32'h900 + i});
    for (int i = 0; i < 8; i++) alu_q.push_back('{rd: 4'(14 + (i % 2)), data: 32'hE00 + i});
    drain(100);
    check("full_seen", full_cycles != 0, 1'b1);
    check("full_r13", shadow[13], 32'h904);

    // Same-rd ALU result must retire after the queued load
    lsu_q.push_back('{rd: 4'd6, data: 32'hAA});
    step();
    alu_q.push_back('{rd: 4'd6, data: 32'hBB});
    drain(30);
    check("waw_r6", shadow[6], 32'hBB);

    // r0 traffic is consumed without any write
    r0_writes = 0;
    alu_q.push_back('{rd: 4'd0, data: 32'hFF});
    lsu_q.push_back('{rd: 4'd0, data: 32'h55});
    drain(30);
    check("r0_writes", r0_writes, 0);
    check("r0_handshakes", alu_q.size() + lsu_q.size(), 0);

    // Reset in the middle of traffic discards the queue
    for (int i = 0; i < 4; i++) lsu_q.push_back('{rd: 4'(1 + i), data: 32'hC00 + i});
    for (int i = 0; i < 6; i++) alu_q.push_back('{rd: 4'(10 + (i % 2)), data: 32'hD00 + i});
    repeat (3) step();
    do_reset();
    repeat (3) step();

    // Random mixed traffic
    for (int c = 0; c < 300; c++) begin
      if (alu_q.size() == 0 && ($urandom % 2) == 0)
        alu_q.push_back('{rd: 4'($urandom), data: $urandom});
      if (lsu_q.size() == 0 && ($urandom % 3) == 0)
        lsu_q.push_back('{rd: 4'($urandom), data: $urandom});
      step();
    end
    drain(200);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
